lcd_sequencer: RTL and testbench

LCD_SEQUENCER -- requirements
Module: lcd_sequencer

---
 rtl/lcd_sequencer_if.sv | 25 ++
 rtl/lcd_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_lcd_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_sequencer_if.sv
// Host request and LCD pin bundle for the character-LCD sequencer.
// master = host side, slave = sequencer side.
interface lcd_sequencer_if;
    logic       init;
    logic       write;
    logic [7:0] data;
    logic       rs;
    logic       busy;
    logic       init_done;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [3:0] lcd_data;
    logic       sf_ce0;

    modport master (
        output init, write, data, rs,
        input  busy, init_done, lcd_e, lcd_rs, lcd_rw, lcd_data, sf_ce0
    );

    modport slave (
        input  init, write, data, rs,
        output busy, init_done, lcd_e, lcd_rs, lcd_rw, lcd_data, sf_ce0
    );
endinterface

// File: rtl/lcd_sequencer.sv
// 4-bit HD44780 sequencer: power-on init + config bytes, then single-byte writes; busy rises one cycle
// after acceptance. Requests are only taken in IDLE (init always, write only after init); others are dropped.
module lcd_sequencer #(
    parameter int unsigned P_POWERON    = 750000,
    parameter int unsigned P_WAIT1      = 205000,
    parameter int unsigned P_WAIT2      = 5000,
    parameter int unsigned P_WAIT3      = 2000,
    parameter int unsigned P_SETUP      = 2,
    parameter int unsigned P_ENABLE     = 12,
    parameter int unsigned P_NIBBLE_GAP = 50,
    parameter int unsigned P_CMD_WAIT   = 2000,
    parameter int unsigned P_CLEAR_WAIT = 82000
) (
    input  logic           clk,
    input  logic           rst_n,
    lcd_sequencer_if.slave bus
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned P_MAX = max2(max2(max2(P_POWERON, P_WAIT1), max2(P_WAIT2, P_WAIT3)),
                                         max2(max2(P_SETUP, P_ENABLE),
                                              max2(P_NIBBLE_GAP, max2(P_CMD_WAIT, P_CLEAR_WAIT))));
    // Counters are loaded with duration-1, so clog2(max) bits suffice.
    localparam int CW = (P_MAX > 1) ? $clog2(P_MAX) : 1;

    localparam logic [CW-1:0] L_POWERON = CW'(P_POWERON - 1);
    localparam logic [CW-1:0] L_WAIT1   = CW'(P_WAIT1 - 1);
    localparam logic [CW-1:0] L_WAIT2   = CW'(P_WAIT2 - 1);
    localparam logic [CW-1:0] L_WAIT3   = CW'(P_WAIT3 - 1);
    localparam logic [CW-1:0] L_SETUP   = CW'(P_SETUP - 1);
    localparam logic [CW-1:0] L_ENABLE  = CW'(P_ENABLE - 1);
    localparam logic [CW-1:0] L_GAP     = CW'(P_NIBBLE_GAP - 1);
    localparam logic [CW-1:0] L_CMD     = CW'(P_CMD_WAIT - 1);
    localparam logic [CW-1:0] L_CLEAR   = CW'(P_CLEAR_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_PWR_WAIT, S_INIT_NIB, S_INIT_WAIT, S_SETUP, S_PULSE, S_GAP, S_WAIT
    } state_t;

    function automatic logic [7:0] cfg_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h28;
            2'd1:    return 8'h06;
            2'd2:    return 8'h0C;
            default: return 8'h01;
        endcase
    endfunction

    function automatic logic [CW-1:0] init_wait(input logic [1:0] idx);
        case (idx)
            2'd0:    return L_WAIT1;
            2'd1:    return L_WAIT2;
            default: return L_WAIT3;
        endcase
    endfunction

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    step, step_nxt;
    logic          in_init, in_init_nxt;
    logic          low_half, low_half_nxt;
    logic [7:0]    byte_q, byte_nxt;
    logic          rs_q, rs_nxt;
    logic          busy_q, init_done_q, init_done_nxt, e_q;
    logic          lcd_rs_q, lcd_rs_nxt;
    logic [3:0]    lcd_data_q, lcd_data_nxt;
    logic [7:0]    cur_byte, next_cfg;
    logic          cnt_zero, clear_cmd, init_nib;

    // step 0-3 are the raw init nibbles, 4-7 the config bytes; user writes run with in_init=0.
    assign init_nib  = in_init && !step[2];
    assign cur_byte  = in_init ? cfg_byte(step[1:0]) : byte_q;
    assign next_cfg  = cfg_byte(step[1:0] + 2'd1);
    assign cnt_zero  = (cnt == '0);
    assign clear_cmd = !rs_q && ((cur_byte == 8'h01) || (cur_byte == 8'h02));

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt_zero ? cnt : cnt - CW'(1);
        step_nxt      = step;
        in_init_nxt   = in_init;
        low_half_nxt  = low_half;
        byte_nxt      = byte_q;
        rs_nxt        = rs_q;
        init_done_nxt = init_done_q;
        lcd_rs_nxt    = lcd_rs_q;
        lcd_data_nxt  = lcd_data_q;

        unique case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (bus.init) begin
                    state_nxt     = S_PWR_WAIT;
                    cnt_nxt       = L_POWERON;
                    step_nxt      = 3'd0;
                    in_init_nxt   = 1'b1;
                    low_half_nxt  = 1'b0;
                    rs_nxt        = 1'b0;
                    init_done_nxt = 1'b0;
                end else if (bus.write && init_done_q) begin
                    state_nxt    = S_SETUP;
                    cnt_nxt      = L_SETUP;
                    in_init_nxt  = 1'b0;
                    low_half_nxt = 1'b0;
                    byte_nxt     = bus.data;
                    rs_nxt       = bus.rs;
                    lcd_rs_nxt   = bus.rs;
                    lcd_data_nxt = bus.data[7:4];
                end
            end
            S_PWR_WAIT: if (cnt_zero) begin
                state_nxt    = S_INIT_NIB;
                cnt_nxt      = L_SETUP;
                lcd_rs_nxt   = 1'b0;
                lcd_data_nxt = 4'h3;
            end
            S_INIT_NIB, S_SETUP: if (cnt_zero) begin
                state_nxt = S_PULSE;
                cnt_nxt   = L_ENABLE;
            end
            S_PULSE: if (cnt_zero) begin
                if (init_nib) begin
                    state_nxt = S_INIT_WAIT;
                    cnt_nxt   = init_wait(step[1:0]);
                end else if (!low_half) begin
                    state_nxt = S_GAP;
                    cnt_nxt   = L_GAP;
                end else begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = clear_cmd ? L_CLEAR : L_CMD;
                end
            end
            S_INIT_WAIT: if (cnt_zero) begin
                step_nxt = step + 3'd1;
                cnt_nxt  = L_SETUP;
                if (step == 3'd3) begin
                    state_nxt    = S_SETUP;
                    low_half_nxt = 1'b0;
                    lcd_data_nxt = next_cfg[7:4];
                end else begin
                    state_nxt    = S_INIT_NIB;
                    lcd_data_nxt = (step == 3'd2) ? 4'h2 : 4'h3;
                end
            end
            S_GAP: if (cnt_zero) begin
                state_nxt    = S_SETUP;
                cnt_nxt      = L_SETUP;
                low_half_nxt = 1'b1;
                lcd_data_nxt = cur_byte[3:0];
            end
            S_WAIT: if (cnt_zero) begin
                low_half_nxt = 1'b0;
                if (in_init && (step != 3'd7)) begin
                    step_nxt     = step + 3'd1;
                    state_nxt    = S_SETUP;
                    cnt_nxt      = L_SETUP;
                    lcd_data_nxt = next_cfg[7:4];
                end else begin
                    state_nxt   = S_IDLE;
                    step_nxt    = 3'd0;
                    in_init_nxt = 1'b0;
                    if (in_init) init_done_nxt = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Strobes and busy are registered from the next state so every phase lasts exactly its count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            step        <= 3'd0;
            in_init     <= 1'b0;
            low_half    <= 1'b0;
            byte_q      <= 8'h00;
            rs_q        <= 1'b0;
            busy_q      <= 1'b0;
            init_done_q <= 1'b0;
            e_q         <= 1'b0;
            lcd_rs_q    <= 1'b0;
            lcd_data_q  <= 4'h0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            step        <= step_nxt;
            in_init     <= in_init_nxt;
            low_half    <= low_half_nxt;
            byte_q      <= byte_nxt;
            rs_q        <= rs_nxt;
            busy_q      <= (state_nxt != S_IDLE);
            init_done_q <= init_done_nxt;
            e_q         <= (state_nxt == S_PULSE);
            lcd_rs_q    <= lcd_rs_nxt;
            lcd_data_q  <= lcd_data_nxt;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.init_done = init_done_q;
    assign bus.lcd_e     = e_q;
    assign bus.lcd_rs    = lcd_rs_q;
    assign bus.lcd_rw    = 1'b0;
    assign bus.lcd_data  = lcd_data_q;
    assign bus.sf_ce0    = 1'b1;

endmodule

// File: tb/tb_lcd_sequencer.sv
// Bench for lcd_sequencer: captured E pulses and busy length are scored against a timeline
// built from the nibble/wait rules with plain arithmetic.
module tb_lcd_sequencer;

    localparam int P_POWERON    = 100;
    localparam int P_WAIT1      = 40;
    localparam int P_WAIT2      = 20;
    localparam int P_WAIT3      = 10;
    localparam int P_SETUP      = 2;
    localparam int P_ENABLE     = 4;
    localparam int P_NIBBLE_GAP = 3;
    localparam int P_CMD_WAIT   = 10;
    localparam int P_CLEAR_WAIT = 30;
    localparam int BUDGET       = 1000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    lcd_sequencer_if sb ();

    lcd_sequencer #(
        .P_POWERON(P_POWERON), .P_WAIT1(P_WAIT1), .P_WAIT2(P_WAIT2), .P_WAIT3(P_WAIT3),
        .P_SETUP(P_SETUP), .P_ENABLE(P_ENABLE), .P_NIBBLE_GAP(P_NIBBLE_GAP),
        .P_CMD_WAIT(P_CMD_WAIT), .P_CLEAR_WAIT(P_CLEAR_WAIT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (sb)
    );

    always #5 clk = ~clk;

    // Reference timeline: cycle offsets from the acceptance edge.
    int         exp_start[$];
    logic [3:0] exp_data[$];
    logic       exp_rs[$];
    int         exp_t;

    int         cap_start[$];
    int         cap_width[$];
    logic [3:0] cap_data[$];
    logic       cap_rs[$];
    int         cap_unstable;
    int         cap_len;
    logic       cap_done0;

    task automatic model_clear();
        exp_start.delete(); exp_data.delete(); exp_rs.delete();
        exp_t = 0;
    endtask

    task automatic model_nibble(input logic [3:0] n, input logic r, input int post);
        exp_start.push_back(exp_t + P_SETUP);
        exp_data.push_back(n);
        exp_rs.push_back(r);
        exp_t += P_SETUP + P_ENABLE + post;
    endtask

    task automatic model_byte(input logic [7:0] b, input logic r);
        int post;
        post = (!r && (b == 8'h01 || b == 8'h02)) ? P_CLEAR_WAIT : P_CMD_WAIT;
        model_nibble(b[7:4], r, P_NIBBLE_GAP);
        model_nibble(b[3:0], r, post);
    endtask

    task automatic model_init();
        model_clear();
        exp_t = P_POWERON;
        model_nibble(4'h3, 1'b0, P_WAIT1);
        model_nibble(4'h3, 1'b0, P_WAIT2);
        model_nibble(4'h3, 1'b0, P_WAIT3);
        model_nibble(4'h2, 1'b0, P_WAIT3);
        model_byte(8'h28, 1'b0);
        model_byte(8'h06, 1'b0);
        model_byte(8'h0C, 1'b0);
        model_byte(8'h01, 1'b0);
    endtask

    task automatic model_write(input logic [7:0] b, input logic r);
        model_clear();
        model_byte(b, r);
    endtask

    task automatic request(input logic do_init, input logic do_write, input logic [7:0] d, input logic r);
        @(negedge clk);
        sb.init  = do_init;
        sb.write = do_write;
        sb.data  = d;
        sb.rs    = r;
    endtask

    // Records pulses until busy drops; kind 1/2 injects a write/init at sample 'at'.
    task automatic capture(input int kind, input int at);
        logic       pe;
        int         st;
        logic [3:0] d;
        logic       r;
        cap_start.delete(); cap_width.delete(); cap_data.delete(); cap_rs.delete();
        cap_unstable = 0; cap_len = -1; pe = 1'b0; st = 0; d = 4'h0; r = 1'b0;
        for (int k = 0; k < BUDGET; k++) begin
            @(negedge clk);
            sb.init = 1'b0; sb.write = 1'b0;
            if (k == 0) cap_done0 = sb.init_done;
            if (sb.lcd_e && !pe) begin
                st = k; d = sb.lcd_data; r = sb.lcd_rs;
                cap_start.push_back(k); cap_data.push_back(d); cap_rs.push_back(r);
            end
            if ((sb.lcd_e || pe) && (sb.lcd_data !== d || sb.lcd_rs !== r)) cap_unstable++;
            if (!sb.lcd_e && pe) cap_width.push_back(k - st);
            pe = sb.lcd_e;
            if (!sb.busy) begin
                cap_len = k;
                break;
            end
            if (k == at && kind == 1) begin
                sb.write = 1'b1; sb.data = 8'($urandom); sb.rs = 1'($urandom);
            end
            if (k == at && kind == 2) sb.init = 1'b1;
        end
    endtask

    task automatic idle_watch(input int n, output int act);
        act = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            sb.init = 1'b0; sb.write = 1'b0;
            if (sb.lcd_e !== 1'b0 || sb.busy !== 1'b0) act++;
        end
    endtask

    // Scoreboard: captured pulse train against the reference timeline.
    task automatic score(input string tag);
        int w;
        checks++;
        if (cap_start.size() !== exp_start.size()) begin
            errors++;
            $display("FAIL %s pulse_count got %0d want %0d", tag, cap_start.size(), exp_start.size());
        end
        for (int i = 0; i < exp_start.size() && i < cap_start.size(); i++) begin
            checks++;
            if (cap_start[i] !== exp_start[i]) begin
                errors++; $display("FAIL %s start[%0d] got %0d want %0d", tag, i, cap_start[i], exp_start[i]);
            end
            checks++;
            if (cap_data[i] !== exp_data[i]) begin
                errors++; $display("FAIL %s data[%0d] got %h want %h", tag, i, cap_data[i], exp_data[i]);
            end
            checks++;
            if (cap_rs[i] !== exp_rs[i]) begin
                errors++; $display("FAIL %s rs[%0d] got %b want %b", tag, i, cap_rs[i], exp_rs[i]);
            end
            w = (i < cap_width.size()) ? cap_width[i] : -1;
            checks++;
            if (w !== P_ENABLE) begin
                errors++; $display("FAIL %s e_width[%0d] got %0d want %0d", tag, i, w, P_ENABLE);
            end
        end
        checks++;
        if (cap_unstable !== 0) begin
            errors++; $display("FAIL %s bus_stable got %0d changes want 0", tag, cap_unstable);
        end
        checks++;
        if (cap_len !== exp_t) begin
            errors++; $display("FAIL %s busy_len got %0d want %0d", tag, cap_len, exp_t);
        end
    endtask

    task automatic test_reset();
        int act;
        rst_n = 1'b0;
        sb.init = 1'b0; sb.write = 1'b0; sb.data = 8'h00; sb.rs = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (sb.lcd_e !== 1'b0)     begin errors++; $display("FAIL reset_e got %b want 0", sb.lcd_e); end
        checks++; if (sb.lcd_rs !== 1'b0)    begin errors++; $display("FAIL reset_rs got %b want 0", sb.lcd_rs); end
        checks++; if (sb.lcd_data !== 4'h0)  begin errors++; $display("FAIL reset_data got %h want 0", sb.lcd_data); end
        checks++; if (sb.busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b want 0", sb.busy); end
        checks++; if (sb.init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done got %b want 0", sb.init_done); end
        checks++; if (sb.lcd_rw !== 1'b0)    begin errors++; $display("FAIL reset_rw got %b want 0", sb.lcd_rw); end
        checks++; if (sb.sf_ce0 !== 1'b1)    begin errors++; $display("FAIL reset_sf_ce0 got %b want 1", sb.sf_ce0); end
        rst_n = 1'b1;
        idle_watch(30, act);
        checks++; if (act !== 0) begin errors++; $display("FAIL post_reset_quiet got %0d active cycles want 0", act); end
    endtask

    task automatic test_write_before_init();
        int act;
        request(1'b0, 1'b1, 8'($urandom), 1'($urandom));
        idle_watch(20, act);
        checks++; if (act !== 0) begin errors++; $display("FAIL write_before_init got %0d active cycles want 0", act); end
    endtask

    task automatic test_init();
        model_init();
        request(1'b1, 1'b0, 8'h00, 1'b0);
        capture(0, -1);
        score("init");
        checks++; if (sb.init_done !== 1'b1) begin errors++; $display("FAIL init_done got %b want 1", sb.init_done); end
        checks++; if (sb.lcd_rw !== 1'b0 || sb.sf_ce0 !== 1'b1) begin
            errors++; $display("FAIL const_pins got rw=%b ce0=%b want rw=0 ce0=1", sb.lcd_rw, sb.sf_ce0);
        end
    endtask

    task automatic test_write_char();
        model_write(8'h41, 1'b1);
        request(1'b0, 1'b1, 8'h41, 1'b1);
        capture(0, -1);
        score("write_41");
    endtask

    task automatic test_clear_wait();
        logic [7:0] bytes [3];
        logic       rss   [3];
        bytes[0] = 8'h01; rss[0] = 1'b0;
        bytes[1] = 8'h01; rss[1] = 1'b1;
        bytes[2] = 8'h02; rss[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            model_write(bytes[i], rss[i]);
            request(1'b0, 1'b1, bytes[i], rss[i]);
            capture(0, -1);
            score($sformatf("clear_%0d", i));
        end
    endtask

    task automatic test_random_writes();
        logic [7:0] b;
        logic       r;
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            if ($urandom_range(0, 3) == 0) b = 8'($urandom_range(1, 2));
            r = 1'($urandom);
            repeat ($urandom_range(0, 4)) @(negedge clk);
            model_write(b, r);
            request(1'b0, 1'b1, b, r);
            capture(0, -1);
            score($sformatf("rand_%0d_%h_%b", i, b, r));
        end
    endtask

    task automatic test_write_while_busy();
        logic [7:0] b;
        logic       r;
        int         act;
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom); r = 1'($urandom);
            model_write(b, r);
            request(1'b0, 1'b1, b, r);
            capture((i == 2) ? 2 : 1, $urandom_range(0, exp_t - 1));
            score($sformatf("busy_inject_%0d", i));
            idle_watch(15, act);
            checks++; if (act !== 0) begin errors++; $display("FAIL busy_inject_quiet_%0d got %0d active cycles want 0", i, act); end
        end
    endtask

    task automatic test_init_write_same_cycle();
        int act;
        model_init();
        request(1'b1, 1'b1, 8'($urandom), 1'($urandom));
        capture(0, -1);
        checks++; if (cap_done0 !== 1'b0) begin errors++; $display("FAIL reinit_clears_done got %b want 0", cap_done0); end
        score("init_and_write");
        checks++; if (sb.init_done !== 1'b1) begin errors++; $display("FAIL reinit_done got %b want 1", sb.init_done); end
        idle_watch(10, act);
        checks++; if (act !== 0) begin errors++; $display("FAIL dropped_write_quiet got %0d active cycles want 0", act); end
    endtask

    task automatic test_reset_mid_pulse();
        int target;
        int act;
        model_init();
        target = exp_start[4] + 1;
        request(1'b1, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k <= target; k++) begin
            @(negedge clk);
            sb.init = 1'b0; sb.write = 1'b0;
        end
        checks++; if (sb.lcd_e !== 1'b1) begin errors++; $display("FAIL pre_reset_e got %b want 1", sb.lcd_e); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (sb.lcd_e !== 1'b0)     begin errors++; $display("FAIL midreset_e got %b want 0", sb.lcd_e); end
        checks++; if (sb.busy !== 1'b0)      begin errors++; $display("FAIL midreset_busy got %b want 0", sb.busy); end
        checks++; if (sb.init_done !== 1'b0) begin errors++; $display("FAIL midreset_init_done got %b want 0", sb.init_done); end
        checks++; if (sb.lcd_data !== 4'h0 || sb.lcd_rs !== 1'b0) begin
            errors++; $display("FAIL midreset_bus got data=%h rs=%b want 0/0", sb.lcd_data, sb.lcd_rs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        request(1'b0, 1'b1, 8'h41, 1'b1);
        idle_watch(20, act);
        checks++; if (act !== 0) begin errors++; $display("FAIL write_after_reset got %0d active cycles want 0", act); end
        model_init();
        request(1'b1, 1'b0, 8'h00, 1'b0);
        capture(0, -1);
        score("reinit");
        model_write(8'h41, 1'b1);
        request(1'b0, 1'b1, 8'h41, 1'b1);
        capture(0, -1);
        score("write_after_reinit");
    endtask

    initial begin
        test_reset();
        test_write_before_init();
        test_init();
        test_write_char();
        test_clear_wait();
        test_random_writes();
        test_write_while_busy();
        test_init_write_same_cycle();
        test_reset_mid_pulse();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
